// File: rtl/ifc_reduce_pkg.sv
// Shared types for the handshaked N-input reduction unit.
// Optional consumed-result counter is enabled by defining IFC_REDUCE_COUNT_EN.
package ifc_reduce_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2,
        OP_NOR = 2'd3
    } reduce_op_e;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/ifc_reduce_slot.sv
// One-entry operand register with valid bit; accepts a load only while empty.
module ifc_reduce_slot
    import ifc_reduce_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             vld,
    output logic             rdy
);

    assign rdy = !vld;

    // A load against a full slot is dropped silently; clear only happens when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            vld <= 1'b0;
        end else if (clear) begin
            vld <= 1'b0;
        end else if (load && rdy) begin
            q   <= data;
            vld <= 1'b1;
        end
    end

endmodule

// File: rtl/ifc_reduce_gate.sv
// Handshaked N-input bitwise OR/AND/XOR/NOR reduction with a one-entry result register.
// Define IFC_REDUCE_COUNT_EN to add the y_count consumed-result counter port.
module ifc_reduce_gate
    import ifc_reduce_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int WIDTH  = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_en,
    output logic [NUM_IN-1:0]       in_rdy,
    input  logic [1:0]              op_sel,
    output logic [WIDTH-1:0]        y_data,
    output logic                    y_rdy,
    input  logic                    y_en
`ifdef IFC_REDUCE_COUNT_EN
    ,
    output logic [COUNT_W-1:0]      y_count
`endif
);

    // Handshake: an operand transfers on channel i when in_en[i] && in_rdy[i] at a
    // rising edge; a result transfers when y_en && y_rdy at a rising edge.
    logic [WIDTH-1:0]  slot_data [NUM_IN];
    logic [NUM_IN-1:0] slot_vld;
    logic              fire;
    logic              drain;
    logic [WIDTH-1:0]  reduced;

    assign fire  = (&slot_vld) && (!y_rdy || y_en);
    assign drain = y_en && y_rdy;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_slot
        ifc_reduce_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (CLK),
            .rst_n (RST_N),
            .load  (in_en[i]),
            .clear (fire),
            .data  (in_data[i*WIDTH +: WIDTH]),
            .q     (slot_data[i]),
            .vld   (slot_vld[i]),
            .rdy   (in_rdy[i])
        );
    end

    always_comb begin
        logic [WIDTH-1:0] acc_or;
        logic [WIDTH-1:0] acc_and;
        logic [WIDTH-1:0] acc_xor;
        acc_or  = '0;
        acc_and = '1;
        acc_xor = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            acc_or  = acc_or  | slot_data[i];
            acc_and = acc_and & slot_data[i];
            acc_xor = acc_xor ^ slot_data[i];
        end
        case (reduce_op_e'(op_sel))
            OP_OR:   reduced = acc_or;
            OP_AND:  reduced = acc_and;
            OP_XOR:  reduced = acc_xor;
            OP_NOR:  reduced = ~acc_or;
            default: reduced = acc_or;
        endcase
    end

    // A fire on the drain edge replaces the old result, so y_rdy stays set.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y_data <= '0;
            y_rdy  <= 1'b0;
        end else if (fire) begin
            y_data <= reduced;
            y_rdy  <= 1'b1;
        end else if (drain) begin
            y_rdy  <= 1'b0;
        end
    end

`ifdef IFC_REDUCE_COUNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y_count <= '0;
        end else if (drain) begin
            y_count <= y_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/ifc_reduce_gate.md
# ifc_reduce_gate

Parametrised, handshaked N-input bitwise reduction unit; the generalised successor of the two-input OR interface block. Each of `NUM_IN` operand channels has its own enable/ready action port backed by a one-entry slot. Once every slot holds an operand, the block computes a `WIDTH`-bit OR/AND/XOR/NOR reduction into a one-entry result register. The result is drained through a ready/enable value port. It sits between operand producers and a single result consumer in the gate-example datapaths and their test wrappers.

## Interface
Parameters:
- `NUM_IN`, default 2: number of operand channels, legal range 2..16.
- `WIDTH`, default 1: operand and result width in bits, legal range 1..64.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `in_data`  in  `NUM_IN*WIDTH`  operand data; channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_en`  in  `NUM_IN`  per-channel operand enable.
- `in_rdy`  out  `NUM_IN`  per-channel slot empty.
- `op_sel`  in  2  reduction op: 0 OR, 1 AND, 2 XOR, 3 NOR.
- `y_data`  out  `WIDTH`  result register.
- `y_rdy`  out  1  result valid.
- `y_en`  in  1  result consume enable.
- `y_count`  out  16  consumed-result count; present only with `IFC_REDUCE_COUNT_EN`.

## Operation
- Each slot i holds `slot_data[i]` and `slot_vld[i]`.
- `in_rdy[i] = !slot_vld[i]` (combinational).
- **Load:** `in_en[i] && in_rdy[i]` at a rising edge writes the channel data and sets `slot_vld[i]`.
- `in_en[i]` while `!in_rdy[i]` is ignored. The slot is unchanged and no error is flagged.
- **Fire:** `fire = &slot_vld && (!y_rdy || y_en)`.
  - On fire, the result register loads `reduce(op_sel, slot_data[0..NUM_IN-1])` and `y_rdy` is set.
  - All `slot_vld` bits clear on the same edge.
- `op_sel` is sampled only on the fire edge. Changes at any other time have no effect.
- Reduction rules:
  - OR = bitwise OR across all channels.
  - AND = bitwise AND.
  - XOR = bitwise XOR (per-bit parity).
  - NOR = bitwise NOT of OR.
  - All results are exactly `WIDTH` bits; there is no carry or extension.
- **Drain:** `y_en && y_rdy` clears `y_rdy` unless fire occurs on the same edge. If fire occurs, the new result replaces the old one and `y_rdy` stays 1.
- `y_en` while `!y_rdy` is ignored.
- Backpressure: if `y_rdy=1` and `y_en=0`, full slots hold and no fire occurs. Channels whose slots are still empty may keep loading.
- Reset values (asynchronous, while `RST_N=0`):
  - all `slot_vld` 0, so all `in_rdy` are 1;
  - `slot_data` 0;
  - `y_data` 0;
  - `y_rdy` 0;
  - `y_count` 0.
- `in_en`/`y_en` are ignored while in reset.
- Reset mid-operation discards partially loaded slots and any undrained result.

## Timing
- Operands arrive independently, in any order and on any cycles.
- Latency: the last operand loads at edge T; `y_rdy` rises after edge T+1, provided the result register was empty or drained at T+1.
- Slots reopen (`in_rdy=1`) after the fire edge, so a new operand can load at fire edge + 1.
- Sustained throughput with all channels loading every other cycle and `y_en` held 1: one result per 2 cycles.
- All outputs are registered or a direct function of registers; there is no combinational path from `in_en`/`y_en` to any output.

## Configuration
- `IFC_REDUCE_COUNT_EN` defined:
  - `y_count` port is present.
  - It increments by 1 on each edge where `y_en && y_rdy`, and wraps from 16'hFFFF to 0.
  - It resets to 0.
- Not defined: the `y_count` port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `ifc_reduce_pkg`:
  - enum `reduce_op_e` with values `OP_OR=0`, `OP_AND=1`, `OP_XOR=2`, `OP_NOR=3`;
  - localparam `COUNT_W=16`.
- Sub-module `ifc_reduce_slot`: one-entry operand register with valid bit, load and clear inputs, and rdy output. It is instantiated `NUM_IN` times via a generate loop.
- Reduction logic and result register live in the top module.

## Test plan
Bench parameters: `NUM_IN=3`, `WIDTH=8`, `CLK` period 10.
- **Reset:** assert `RST_N=0` mid-cycle. Required: `in_rdy=3'b111`, `y_rdy=0`, `y_data=8'h00` immediately, independent of the clock.
- **OR fire:** load 8'h01, 8'h10, 8'h80 on ch0/ch1/ch2 in three separate cycles with `op_sel=0`. Required: `y_rdy=1` and `y_data=8'h91` one edge after the ch2 load; `in_rdy=3'b111` at that point.
- **Mode sweep:** operands F0, 3C, AA. Required: AND→8'h20, XOR→8'h66, NOR→8'h01.
- **Backpressure:** hold `y_en=0` with a result pending and all slots full; then pulse `y_en`. Required: the slots fire on that same edge and `y_rdy` stays 1 with the new value.
- **Protocol violation:** `in_en[0]` with 8'hFF while slot 0 already holds 8'h0F. Required: the later result uses 8'h0F.
- **Counter** (`IFC_REDUCE_COUNT_EN`): preload the count to 16'hFFFF via 65535 drains, then drain once more. Required: `y_count=0`. Build without the macro and confirm the port is absent.
